// File: rtl/glyph_blitter.sv
// glyph_blitter: renders one character glyph into a stream of pixels for the
// VGA adapter plot port. Fonts are row-addressed ROMs ({ascii, row} -> one
// glyph row); each row is fetched, shifted out MSB-first one pixel per cycle,
// offset by (x0, y0), clipped to the screen and held under back-pressure.
module glyph_blitter #(
    parameter int SMALL_W     = 8,
    parameter int LARGE_W     = 16,
    parameter int ASCII_W     = 7,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120,
    parameter int COLOUR_W    = 3,
    parameter     CHAR_DATA_S = "char_data_s.mif",
    parameter     CHAR_DATA_L = "char_data_l.mif"
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                ready,
    input  logic [ASCII_W-1:0]  ascii,
    input  logic                size,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic [COLOUR_W-1:0] bg_colour,
    input  logic                opaque,
    input  logic                plot_ready,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                done
);

    localparam int SB      = $clog2(SMALL_W);
    localparam int LB      = $clog2(LARGE_W);
    localparam int S_DEPTH = (1 << ASCII_W) * SMALL_W;
    localparam int L_DEPTH = (1 << ASCII_W) * LARGE_W;

    localparam logic [LB-1:0] SMALL_LAST = LB'(SMALL_W - 1);
    localparam logic [LB-1:0] LARGE_LAST = LB'(LARGE_W - 1);

    // Handshake: a request is taken on a rising edge where start && ready.
    // Pixels: a pixel transfers on a rising edge where plot && plot_ready;
    // while plot=1 and plot_ready=0 the pixel outputs are held unchanged.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAW  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [LB-1:0]       row_q, row_d;
    logic [LB-1:0]       col_q, col_d;
    logic [LARGE_W-1:0]  shift_q, shift_d;

    logic [ASCII_W-1:0]  ascii_q, ascii_d;
    logic                size_q, size_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [COLOUR_W-1:0] fg_q, fg_d;
    logic [COLOUR_W-1:0] bg_q, bg_d;
    logic                opaque_q, opaque_d;

    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                plot_q, plot_d;

    // Font ROMs. Contents come from the .mif init files at synthesis; the
    // address is registered and q is read combinationally (1-cycle latency).
    (* ram_init_file = CHAR_DATA_S *)
    logic [SMALL_W-1:0] rom_s [0:S_DEPTH-1] = '{default: '0};
    (* ram_init_file = CHAR_DATA_L *)
    logic [LARGE_W-1:0] rom_l [0:L_DEPTH-1] = '{default: '0};

    logic [ASCII_W+SB-1:0] rom_addr_s_q, rom_addr_s_d;
    logic [ASCII_W+LB-1:0] rom_addr_l_q, rom_addr_l_d;
    logic [SMALL_W-1:0]    rom_s_q;
    logic [LARGE_W-1:0]    rom_l_q;

    logic [LARGE_W-1:0]  row_data;
    logic [LB-1:0]       last_idx;
    logic                stall;
    logic                bit_v;
    logic                clipped;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                pix_plot;

    assign rom_s_q = rom_s[rom_addr_s_q];
    assign rom_l_q = rom_l[rom_addr_l_q];

    // A presented pixel that downstream refuses freezes the draw datapath.
    assign stall = plot_q && !plot_ready;

    // Current-pixel datapath: position, clipping and colour for column col_q.
    always_comb begin
        rom_addr_s_d = {ascii_q, row_q[SB-1:0]};
        rom_addr_l_d = {ascii_q, row_q};
        row_data     = '0;
        if (size_q) begin
            row_data = rom_l_q;
        end else begin
            // Small rows are MSB-aligned so the shifter always emits bit LARGE_W-1.
            row_data[LARGE_W-1 -: SMALL_W] = rom_s_q;
        end
        last_idx   = size_q ? LARGE_LAST : SMALL_LAST;
        bit_v      = shift_q[LARGE_W-1];
        pix_x      = x0_q + X_W'(col_q);
        pix_y      = y0_q + Y_W'(row_q);
        clipped    = (int'(pix_x) >= X_MAX) || (int'(pix_y) >= Y_MAX);
        pix_plot   = !clipped && (opaque_q || bit_v);
        pix_colour = (bit_v || !opaque_q) ? fg_q : bg_q;
    end

    // Next-state logic for the glyph FSM, counters, latched request and pixel outputs.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        shift_d  = shift_q;
        ascii_d  = ascii_q;
        size_d   = size_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        fg_d     = fg_q;
        bg_d     = bg_q;
        opaque_d = opaque_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        // A refused pixel stays presented; an accepted or absent one is retired.
        plot_d   = stall ? plot_q : 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ascii_d  = ascii;
                    size_d   = size;
                    x0_d     = x0;
                    y0_d     = y0;
                    fg_d     = fg_colour;
                    bg_d     = bg_colour;
                    opaque_d = opaque;
                    row_d    = '0;
                    col_d    = '0;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                shift_d = row_data;
                col_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                if (!stall) begin
                    x_d      = pix_x;
                    y_d      = pix_y;
                    colour_d = pix_colour;
                    plot_d   = pix_plot;
                    shift_d  = shift_q << 1;
                    col_d    = col_q + LB'(1);
                    if (col_q == last_idx) begin
                        col_d = '0;
                        if (row_q == last_idx) begin
                            state_d = DONE;
                        end else begin
                            row_d   = row_q + LB'(1);
                            state_d = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM address registers (no reset, as in the embedded memory block).
    always_ff @(posedge clock) begin
        rom_addr_s_q <= rom_addr_s_d;
        rom_addr_l_q <= rom_addr_l_d;
    end

    // FSM and datapath registers with synchronous reset; reset aborts any glyph.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            shift_q  <= '0;
            ascii_q  <= '0;
            size_q   <= 1'b0;
            x0_q     <= '0;
            y0_q     <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            opaque_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            shift_q  <= shift_d;
            ascii_q  <= ascii_d;
            size_q   <= size_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            fg_q     <= fg_d;
            bg_q     <= bg_d;
            opaque_q <= opaque_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// Directed bench for glyph_blitter: opaque/transparent small glyphs, a clipped
// large glyph, a downstream stall, a start while busy and a mid-glyph reset.
module tb_glyph_blitter;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       ready;
    logic [6:0] ascii;
    logic       size;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] fg_colour;
    logic [2:0] bg_colour;
    logic       opaque;
    logic       plot_ready;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Results of the last run_glyph call (cycle numbers count edges after accept).
    logic [7:0] px_q[$];
    logic [6:0] py_q[$];
    logic [2:0] pc_q[$];
    int         first_cyc;
    int         done_cyc;
    int         done_cnt;
    int         bad_cnt;
    int         unstable_cnt;
    int         stall_rem;
    logic       stalled;
    logic       ready_start;
    logic       ready_after;

    always #5 clock = ~clock;

    glyph_blitter dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .ascii      (ascii),
        .size       (size),
        .x0         (x0),
        .y0         (y0),
        .fg_colour  (fg_colour),
        .bg_colour  (bg_colour),
        .opaque     (opaque),
        .plot_ready (plot_ready),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .done       (done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Start one glyph and record every accepted pixel until one cycle past done.
    // Optionally stalls plot_ready on pixel (sx, sy) and pulses a second start.
    task automatic run_glyph(input logic [6:0] a, input logic sz, input logic [7:0] gx,
                             input logic [6:0] gy, input logic [2:0] fg, input logic [2:0] bg,
                             input logic op, input int max_cyc, input int restart_at,
                             input int stall_len, input logic [7:0] sx, input logic [6:0] sy);
        logic [7:0] hx;
        logic [6:0] hy;
        logic [2:0] hc;
        px_q.delete();
        py_q.delete();
        pc_q.delete();
        first_cyc    = -1;
        done_cyc     = -1;
        done_cnt     = 0;
        bad_cnt      = 0;
        unstable_cnt = 0;
        stall_rem    = 0;
        stalled      = 1'b0;
        ready_after  = 1'b0;
        hx = '0;
        hy = '0;
        hc = '0;
        @(negedge clock);
        ascii = a; size = sz; x0 = gx; y0 = gy;
        fg_colour = fg; bg_colour = bg; opaque = op;
        plot_ready = 1'b1;
        start = 1'b1;
        ready_start = ready;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge clock);
            @(negedge clock);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                ready_after = ready;
                break;
            end
            if (cyc == restart_at) begin
                start = 1'b1; ascii = 7'h7F; size = 1'b1; x0 = 8'd0; y0 = 7'd0;
                fg_colour = 3'b010; bg_colour = 3'b100; opaque = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (stall_len > 0 && !stalled && plot === 1'b1 && x == sx && y == sy) begin
                stalled = 1'b1; stall_rem = stall_len; hx = x; hy = y; hc = colour;
            end else if (stall_rem > 0) begin
                if (plot !== 1'b1 || x !== hx || y !== hy || colour !== hc) unstable_cnt++;
            end
            if (stall_rem > 0) begin
                plot_ready = 1'b0;
                stall_rem--;
            end else begin
                plot_ready = 1'b1;
            end
            if (plot === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (plot === 1'b1 && (x >= 8'd160 || y >= 7'd120)) bad_cnt++;
            if (plot === 1'b1 && plot_ready === 1'b1) begin
                px_q.push_back(x);
                py_q.push_back(y);
                pc_q.push_back(colour);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start = 1'b0;
        plot_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; plot_ready = 1'b1;
        ascii = '0; size = 1'b0; x0 = '0; y0 = '0;
        fg_colour = '0; bg_colour = '0; opaque = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL reset_plot: got %b want 0", plot); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (x !== 8'd0 || y !== 7'd0) begin errors++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", x, y); end
        checks++; if (colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %b want 000", colour); end
    endtask

    // Glyph 0x01 opaque at (10,20): diagonal in fg 111, everything else bg 001.
    task automatic test_opaque_small();
        int bad_px;
        run_glyph(7'h01, 1'b0, 8'd10, 7'd20, 3'b111, 3'b001, 1'b1, 200, -1, 0, 8'd0, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            int r;
            int c;
            r = i / 8;
            c = i % 8;
            if (px_q[i] !== 8'(10 + c) || py_q[i] !== 7'(20 + r) ||
                pc_q[i] !== ((r == c) ? 3'b111 : 3'b001)) bad_px++;
        end
        checks++; if (ready_start !== 1'b1) begin errors++; $display("FAIL opaque_ready_before: got %b want 1", ready_start); end
        checks++; if (px_q.size() != 64) begin errors++; $display("FAIL opaque_plot_count: got %0d want 64", px_q.size()); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL opaque_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (first_cyc != 3) begin errors++; $display("FAIL opaque_first_plot: got cycle %0d want 3", first_cyc); end
        checks++; if (done_cyc != 80) begin errors++; $display("FAIL opaque_done_cycle: got %0d want 80", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL opaque_done_pulses: got %0d want 1", done_cnt); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL opaque_ready_after: got %b want 1", ready_after); end
    endtask

    // Same glyph transparent: only the 8 diagonal pixels are plotted.
    task automatic test_transparent_small();
        int bad_px;
        run_glyph(7'h01, 1'b0, 8'd10, 7'd20, 3'b111, 3'b001, 1'b0, 200, -1, 0, 8'd0, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            if (px_q[i] !== 8'(10 + i) || py_q[i] !== 7'(20 + i) || pc_q[i] !== 3'b111) bad_px++;
        end
        checks++; if (px_q.size() != 8) begin errors++; $display("FAIL transp_plot_count: got %0d want 8", px_q.size()); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL transp_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (first_cyc != 3) begin errors++; $display("FAIL transp_first_plot: got cycle %0d want 3", first_cyc); end
        checks++; if (done_cyc != 80) begin errors++; $display("FAIL transp_done_cycle: got %0d want 80", done_cyc); end
    endtask

    // Large solid glyph at (150,110): only the 10x10 on-screen corner is plotted.
    task automatic test_clip_large();
        int bad_px;
        run_glyph(7'h7F, 1'b1, 8'd150, 7'd110, 3'b110, 3'b001, 1'b1, 400, -1, 0, 8'd0, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            if (px_q[i] !== 8'(150 + (i % 10)) || py_q[i] !== 7'(110 + (i / 10)) ||
                pc_q[i] !== 3'b110) bad_px++;
        end
        checks++; if (px_q.size() != 100) begin errors++; $display("FAIL clip_plot_count: got %0d want 100", px_q.size()); end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL clip_offscreen: got %0d off-screen plots want 0", bad_cnt); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL clip_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (first_cyc != 3) begin errors++; $display("FAIL clip_first_plot: got cycle %0d want 3", first_cyc); end
        checks++; if (done_cyc != 288) begin errors++; $display("FAIL clip_done_cycle: got %0d want 288", done_cyc); end
    endtask

    // Solid small glyph at (0,0) with plot_ready low for 5 cycles on pixel (3,0).
    task automatic test_back_pressure();
        int bad_px;
        run_glyph(7'h7F, 1'b0, 8'd0, 7'd0, 3'b101, 3'b010, 1'b1, 200, -1, 5, 8'd3, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            if (px_q[i] !== 8'(i % 8) || py_q[i] !== 7'(i / 8) || pc_q[i] !== 3'b101) bad_px++;
        end
        checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL bp_stall_seen: got %b want 1", stalled); end
        checks++; if (unstable_cnt != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable_cnt); end
        checks++; if (px_q.size() != 64) begin errors++; $display("FAIL bp_plot_count: got %0d want 64", px_q.size()); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL bp_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (done_cyc != 85) begin errors++; $display("FAIL bp_done_cycle: got %0d want 85", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); end
    endtask

    // A second start mid-glyph with different parameters must change nothing.
    task automatic test_busy_start();
        int bad_px;
        run_glyph(7'h01, 1'b0, 8'd10, 7'd20, 3'b111, 3'b001, 1'b1, 200, 20, 0, 8'd0, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            if (px_q[i] !== 8'(10 + (i % 8)) || py_q[i] !== 7'(20 + (i / 8)) ||
                pc_q[i] !== (((i % 8) == (i / 8)) ? 3'b111 : 3'b001)) bad_px++;
        end
        checks++; if (px_q.size() != 64) begin errors++; $display("FAIL busy_plot_count: got %0d want 64", px_q.size()); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL busy_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (done_cyc != 80) begin errors++; $display("FAIL busy_done_cycle: got %0d want 80", done_cyc); end
        checks++; if (ready_after !== 1'b1) begin errors++; $display("FAIL busy_ready_after: got %b want 1", ready_after); end
    endtask

    // Reset 30 cycles into a glyph aborts it; a fresh glyph then renders from row 0.
    task automatic test_reset_mid_glyph();
        int late_done;
        int bad_px;
        @(negedge clock);
        ascii = 7'h7F; size = 1'b0; x0 = 8'd0; y0 = 7'd0;
        fg_colour = 3'b011; bg_colour = 3'b000; opaque = 1'b1;
        plot_ready = 1'b1;
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", ready); end
        checks++; if (plot !== 1'b0) begin errors++; $display("FAIL midreset_plot: got %b want 0", plot); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
        reset = 1'b0;
        late_done = 0;
        repeat (90) begin
            @(negedge clock);
            if (done === 1'b1 || plot === 1'b1) late_done++;
        end
        checks++; if (late_done != 0) begin errors++; $display("FAIL midreset_abort: got %0d done/plot cycles want 0", late_done); end
        run_glyph(7'h01, 1'b0, 8'd10, 7'd20, 3'b111, 3'b001, 1'b0, 200, -1, 0, 8'd0, 7'd0);
        bad_px = 0;
        for (int i = 0; i < px_q.size(); i++) begin
            if (px_q[i] !== 8'(10 + i) || py_q[i] !== 7'(20 + i)) bad_px++;
        end
        checks++; if (px_q.size() != 8) begin errors++; $display("FAIL after_reset_count: got %0d want 8", px_q.size()); end
        checks++; if (bad_px != 0) begin errors++; $display("FAIL after_reset_pixels: got %0d wrong pixels want 0", bad_px); end
        checks++; if (done_cyc != 80) begin errors++; $display("FAIL after_reset_done: got %0d want 80", done_cyc); end
    endtask

    initial begin
        logic [7:0] srow;
        reset = 1'b1;
        start = 1'b0;
        plot_ready = 1'b1;
        #1;
        // Bench fonts: small 0x7F solid, small 0x01 diagonal, large 0x7F solid.
        for (int r = 0; r < 8; r++) begin
            srow = 8'h80;
            srow = srow >> r;
            dut.rom_s[127 * 8 + r] = 8'hFF;
            dut.rom_s[1 * 8 + r]   = srow;
        end
        for (int r = 0; r < 16; r++) begin
            dut.rom_l[127 * 16 + r] = 16'hFFFF;
        end
        test_reset();
        test_opaque_small();
        test_transparent_small();
        test_clip_large();
        test_back_pressure();
        test_busy_start();
        test_reset_mid_glyph();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Parametrised successor to the fixed two-font character ROM.
- Fonts are stored row-addressed: ROM address is {ascii, row}, data is one glyph row. This replaces one full-glyph word per character.
- On a start handshake the block reads one glyph row at a time and serialises it into one pixel per cycle (x, y, colour, plot) for the VGA adapter's plot port.
- Supports two font sizes, a transparent/opaque background mode, screen clipping and downstream back-pressure.

Parameters:
- SMALL_W, 8: small glyph edge in pixels (power of 2).
- LARGE_W, 16: large glyph edge in pixels (power of 2).
- ASCII_W, 7: character code width.
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- X_MAX, 160: screen width; pixels with x >= X_MAX are clipped.
- Y_MAX, 120: screen height; pixels with y >= Y_MAX are clipped.
- COLOUR_W, 3: colour width.
- CHAR_DATA_S, "char_data_s.mif": small font init file, 2^ASCII_W*SMALL_W words of SMALL_W bits.
- CHAR_DATA_L, "char_data_l.mif": large font init file, 2^ASCII_W*LARGE_W words of LARGE_W bits.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request valid
- ready  out  1  block idle; accepts start
- ascii  in  ASCII_W  character code
- size  in  1  0 = small font, 1 = large font
- x0  in  X_W  glyph top-left x
- y0  in  Y_W  glyph top-left y
- fg_colour  in  COLOUR_W  colour for 1 bits
- bg_colour  in  COLOUR_W  colour for 0 bits
- opaque  in  1  1 = plot 0 bits in bg_colour; 0 = skip 0 bits
- plot_ready  in  1  downstream accepts the current pixel
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel valid
- done  out  1  one-cycle pulse when the glyph is complete

Behaviour:
- Fixed decision: one clock named clock; reset is synchronous and active-high, named reset.
- Reset values:
  - state IDLE; ready=1; plot=0; done=0; x=0; y=0; colour=0.
  - Row and column counters are 0.
  - Reset asserted mid-glyph aborts at the next edge, with no done pulse.
- Accept: start && ready at a clock edge.
  - ascii, size, x0, y0, fg_colour, bg_colour and opaque are latched.
  - Inputs are ignored while ready=0; start while busy is dropped, not queued.
- W = SMALL_W if the latched size=0, else LARGE_W.
- Two internal single-port ROMs (altsyncram, ROM mode, Cyclone V, registered address, 1-cycle read latency, unregistered q). Only the selected ROM's output is used.
- FSM states: IDLE, FETCH, WAIT, DRAW, DONE.
  - IDLE -> FETCH on accept.
  - FETCH: drive address {ascii, row}; -> WAIT.
  - WAIT: ROM q valid; load row shift register; col=0; -> DRAW.
  - DRAW: one column per cycle. The current bit is the row MSB-first (MSB = leftmost pixel).
    - Output x = x0+col and y = y0+row, computed modulo 2^X_W and 2^Y_W before clipping.
    - Opaque: plot=1 for every unclipped bit; colour = bit ? fg_colour : bg_colour.
    - Transparent: plot=1 only for 1 bits; colour=fg_colour. Zero bits give plot=0 and still consume one cycle.
    - Clipped pixel (x >= X_MAX or y >= Y_MAX): plot=0; the column advances.
    - The column advances when plot=0, or when plot=1 && plot_ready=1.
    - If plot=1 && plot_ready=0: hold x, y, colour, plot and the column unchanged.
    - On the last column advancing: if row < W-1 then row++ and -> FETCH; else -> DONE.
  - DONE: done=1 for exactly one cycle; ready stays 0; -> IDLE with ready=1 the next cycle.
- Latency with no stalls:
  - First pixel is presented 3 cycles after the accept edge.
  - Each row costs W+2 cycles.
  - Small glyph: 80 cycles from accept to the DONE cycle. Large glyph: 288 cycles.
- Outputs x, y, colour and plot are registered or derived from registered state only; no combinational path from plot_ready to plot.
- size changing while busy has no effect, since it is latched at accept.

Test Plan:
Bench fonts: small glyph 0x7F = all rows 8'hFF; small glyph 0x01 row r = 8'h80>>r; large glyph 0x7F = all rows 16'hFFFF.
- Opaque small glyph: start with ascii=0x01, size=0, x0=10, y0=20, opaque=1, fg=3'b111, bg=3'b001, plot_ready=1.
  - Exactly 64 plots, with colour 111 only at (10+r, 20+r) and 001 elsewhere.
  - First plot 3 cycles after accept; done pulses once, 80 cycles after accept; then ready=1.
- Transparent small glyph: same as above with opaque=0.
  - Exactly 8 plots, at (10,20), (11,21) … (17,27).
  - done timing unchanged (80 cycles).
- Large glyph with clipping: ascii=0x7F, size=1, x0=150, y0=110, opaque=1.
  - Plots only for x in 150..159 and y in 110..119, i.e. 100 plots.
  - No x >= 160 or y >= 120 ever appears with plot=1.
  - done at cycle 288.
- Back-pressure: small glyph 0x7F with plot_ready held low for 5 cycles on pixel (3,0).
  - x, y, colour and plot stay stable during the stall.
  - No pixel is lost or duplicated; 64 plots total; done at cycle 85.
- Busy and reset: a second start during drawing is ignored.
  - reset asserted at cycle 30: next cycle ready=1, plot=0, done=0.
  - A new start afterwards renders correctly from row 0.
